// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship hazard source.
// Holds FSM encodings, LFSR taps and repair-side indices.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ARMED = 3'b010,
    ST_FIRE  = 3'b100
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] SIDE_LR = 2'd0;
  localparam logic [1:0] SIDE_RR = 2'd1;
  localparam logic [1:0] SIDE_TR = 2'd2;
  localparam logic [1:0] SIDE_BR = 2'd3;

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift) with lock-up guard.
// Ports: Clk, Reset (sync, active-high), state (current LFSR value).
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] state
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= SEED;
    end else if (state == 16'h0) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0);
    end
  end

endmodule

// File: rtl/nexys_starship_event_gen.sv
// Random break scheduler: LFSR, game-tick divider and event FSM.
// Ports: Clk/Reset, play_flag, gameover_ctrl, level in; timer_clk,
// random_hex, LR/RR/TR/BR_random strobes, one-hot q_* state out.
module nexys_starship_event_gen
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          TICK_DIV = 50_000_000,
  parameter int          MIN_GAP  = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [1:0] level,
  output logic       timer_clk,
  output logic [3:0] random_hex,
  output logic       LR_random,
  output logic       RR_random,
  output logic       TR_random,
  output logic       BR_random,
  output logic       q_Idle,
  output logic       q_Armed,
  output logic       q_Fire
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(TICK_DIV / 2);

  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;
  logic [8:0]    gap;
  logic [8:0]    gap_cnt;
  logic [8:0]    gap_nxt;
  logic [3:0]    strobe;
  logic [3:0]    strobe_nxt;
  logic [3:0]    hex_nxt;
  state_t        state;
  state_t        state_nxt;

  nexys_starship_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[11:8];

  assign tick    = (div_cnt == LAST);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;

  // Higher level shifts more random bits away -> shorter gaps.
  assign gap = 9'(MIN_GAP) + {1'b0, lfsr[7:0] >> {level, 1'b0}};

  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap_cnt;
    strobe_nxt = '0;
    hex_nxt    = random_hex;
    if (gameover_ctrl) begin
      state_nxt = ST_IDLE;
      gap_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play_flag) begin
            state_nxt = ST_ARMED;
            gap_nxt   = gap;
          end
        end
        ST_ARMED: begin
          if (tick) begin
            if (gap_cnt == 9'd0) begin
              state_nxt = ST_FIRE;
              hex_nxt   = (lfsr[15:12] == 4'h0) ? 4'h1 : lfsr[15:12];
              unique case (lfsr[1:0])
                SIDE_LR: strobe_nxt = 4'b0001;
                SIDE_RR: strobe_nxt = 4'b0010;
                SIDE_TR: strobe_nxt = 4'b0100;
                SIDE_BR: strobe_nxt = 4'b1000;
              endcase
            end else begin
              gap_nxt = gap_cnt - 9'd1;
            end
          end
        end
        ST_FIRE: begin
          state_nxt = ST_ARMED;
          gap_nxt   = gap;
        end
        default: begin
          state_nxt = ST_IDLE;
          gap_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt    <= '0;
      timer_clk  <= 1'b0;
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      random_hex <= 4'h1;
      strobe     <= '0;
    end else begin
      div_cnt    <= div_nxt;
      timer_clk  <= (div_nxt >= HALF);
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      random_hex <= hex_nxt;
      strobe     <= strobe_nxt;
    end
  end

  assign LR_random = strobe[SIDE_LR];
  assign RR_random = strobe[SIDE_RR];
  assign TR_random = strobe[SIDE_TR];
  assign BR_random = strobe[SIDE_BR];

  assign q_Idle  = state[0];
  assign q_Armed = state[1];
  assign q_Fire  = state[2];

endmodule
